// File: rtl/mult8_seq_4x4_accum.sv
// Sequential 8x8 unsigned multiplier built from one shared 4x4 core stepped over the four nibble products.
// Optional build macro MULT_ERR_MON_EN adds an exact-reference error flag and a saturating error counter.

module mult4x4_core #(
    parameter int CORE_SEL = 0  // 0 = exact product, 1 = all-ones stub for approximate-core evaluation
) (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    if (CORE_SEL == 0) begin : g_exact
        assign p = a * b;
    end else begin : g_all_ones
        assign p = 8'hFF;
    end
endmodule

module mult8_seq_4x4_accum #(
    parameter int CORE_REG  = 0,
    parameter int ERR_CNT_W = 16,
    parameter int CORE_SEL  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] P,
    output logic        ovf
`ifdef MULT_ERR_MON_EN
    ,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [7:0]  a_q, b_q;
    logic [1:0]  step;
    logic [16:0] acc;
    logic [3:0]  core_a, core_b;
    logic [7:0]  core_p;
    logic [7:0]  add_pp;
    logic [3:0]  add_sh;
    logic        add_en, add_last, issue_en;
    logic        accept;

    if (ERR_CNT_W < 1) begin : g_bad_err_cnt_w
        $error("ERR_CNT_W must be at least 1");
    end

    function automatic logic [3:0] shift_of(input logic [1:0] s);
        case (s)
            2'd0:    return 4'd0;
            2'd3:    return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    // Step order: ll, lh, hl, hh -> step[1] picks the A nibble, step[0] the B nibble.
    assign core_a = step[1] ? a_q[7:4] : a_q[3:0];
    assign core_b = step[0] ? b_q[7:4] : b_q[3:0];

    mult4x4_core #(.CORE_SEL(CORE_SEL)) u_core (
        .a(core_a),
        .b(core_b),
        .p(core_p)
    );

    if (CORE_REG != 0) begin : g_core_reg
        logic [7:0] pp_q;
        logic [3:0] sh_q;
        logic       en_q, last_q, iss_done;

        // Issue side walks the steps; the add side trails one cycle behind on the registered product.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pp_q     <= '0;
                sh_q     <= '0;
                en_q     <= 1'b0;
                last_q   <= 1'b0;
                iss_done <= 1'b0;
            end else if (accept) begin
                en_q     <= 1'b0;
                last_q   <= 1'b0;
                iss_done <= 1'b0;
            end else begin
                pp_q   <= core_p;
                sh_q   <= shift_of(step);
                en_q   <= issue_en;
                last_q <= issue_en && (step == 2'd3);
                if (issue_en && (step == 2'd3)) iss_done <= 1'b1;
            end
        end

        assign issue_en = (state == CALC) && !iss_done;
        assign add_pp   = pp_q;
        assign add_sh   = sh_q;
        assign add_en   = en_q;
        assign add_last = last_q;
    end else begin : g_core_comb
        assign issue_en = (state == CALC);
        assign add_pp   = core_p;
        assign add_sh   = shift_of(step);
        assign add_en   = issue_en;
        assign add_last = (step == 2'd3);
    end

    // NOTE: every register here uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            step      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= A;
                        b_q   <= B;
                        acc   <= '0;
                        step  <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (add_en) acc <= acc + ({9'b0, add_pp} << add_sh);
                    if (issue_en) step <= step + 2'd1;
                    if (add_en && add_last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Retiring and accepting in the same cycle keeps the input side bubble-free.
                    if (accept) begin
                        a_q       <= A;
                        b_q       <= B;
                        acc       <= '0;
                        step      <= '0;
                        state     <= CALC;
                        out_valid <= 1'b0;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign P   = acc[15:0];
    assign ovf = acc[16];

`ifdef MULT_ERR_MON_EN
    logic [15:0] exact;

    assign exact = a_q * b_q;
    assign err   = out_valid && (acc != {1'b0, exact});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && err && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mult8_seq_4x4_accum.sv
// Self-checking bench: three DUTs (CORE_REG=0 exact, CORE_REG=1 exact, CORE_REG=0 all-ones core),
// each exercised with scenario tasks against a scoreboard queue of expected {ovf,P}.

module tb_mult8_seq_4x4_accum;
    localparam int ND = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ND-1:0]         in_valid, out_ready;
    logic [ND-1:0][7:0]    a, b;
    logic [ND-1:0]         in_ready, out_valid, ovf;
    logic [ND-1:0][15:0]   p;
`ifdef MULT_ERR_MON_EN
    logic [ND-1:0]         err;
    logic [ND-1:0][15:0]   err_cnt;
`endif

    int checks = 0;
    int passed = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    mult8_seq_4x4_accum #(.CORE_REG(0), .ERR_CNT_W(16), .CORE_SEL(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(a[0]), .B(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .P(p[0]), .ovf(ovf[0])
`ifdef MULT_ERR_MON_EN
        , .err(err[0]), .err_cnt(err_cnt[0])
`endif
    );

    mult8_seq_4x4_accum #(.CORE_REG(1), .ERR_CNT_W(16), .CORE_SEL(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(a[1]), .B(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .P(p[1]), .ovf(ovf[1])
`ifdef MULT_ERR_MON_EN
        , .err(err[1]), .err_cnt(err_cnt[1])
`endif
    );

    mult8_seq_4x4_accum #(.CORE_REG(0), .ERR_CNT_W(16), .CORE_SEL(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(a[2]), .B(b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .P(p[2]), .ovf(ovf[2])
`ifdef MULT_ERR_MON_EN
        , .err(err[2]), .err_cnt(err_cnt[2])
`endif
    );

    // Reference: exact product, or the all-ones core summed over the four shifted steps.
    function automatic logic [16:0] model(input int d, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] t;
        if (d == 2) return 17'h11FDF;
        t = x * y;
        return {1'b0, t};
    endfunction

    function automatic int lat(input int d);
        return (d == 1) ? 5 : 4;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        a = '0;
        b = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset(input int d);
        do_reset();
        checks++; if (in_ready[d] !== 1'b1) $display("FAIL reset_in_ready dut%0d got %b want 1", d, in_ready[d]); else passed++;
        checks++; if (out_valid[d] !== 1'b0) $display("FAIL reset_out_valid dut%0d got %b want 0", d, out_valid[d]); else passed++;
        checks++; if (p[d] !== 16'h0) $display("FAIL reset_p dut%0d got %h want 0000", d, p[d]); else passed++;
        checks++; if (ovf[d] !== 1'b0) $display("FAIL reset_ovf dut%0d got %b want 0", d, ovf[d]); else passed++;
    endtask

    task automatic test_basic(input int d);
        logic [16:0] e;
        int bad;
        do_reset();
        e = model(d, 8'hFF, 8'hFF);
        @(posedge clk); #1;
        a[d] = 8'hFF; b[d] = 8'hFF; in_valid[d] = 1'b1; out_ready[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        bad = 0;
        for (int k = 1; k <= lat(d) + 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid[d] !== (k == lat(d))) bad++;
            if (k == lat(d)) begin
                checks++; if (p[d] !== e[15:0]) $display("FAIL basic_p dut%0d got %h want %h", d, p[d], e[15:0]); else passed++;
                checks++; if (ovf[d] !== e[16]) $display("FAIL basic_ovf dut%0d got %b want %b", d, ovf[d], e[16]); else passed++;
`ifdef MULT_ERR_MON_EN
                checks++; if (err[d] !== (d == 2)) $display("FAIL basic_err dut%0d got %b want %b", d, err[d], d == 2); else passed++;
`endif
            end
        end
        checks++; if (bad != 0) $display("FAIL basic_timing dut%0d got %0d bad cycles want 0 (latency %0d)", d, bad, lat(d)); else passed++;
`ifdef MULT_ERR_MON_EN
        checks++; if (err_cnt[d] !== ((d == 2) ? 16'd1 : 16'd0)) $display("FAIL basic_err_cnt dut%0d got %0d want %0d", d, err_cnt[d], (d == 2) ? 1 : 0); else passed++;
`endif
    endtask

    task automatic test_backpressure(input int d);
        logic [16:0] e;
        int bad, n, xfers;
        do_reset();
        e = model(d, 8'h12, 8'h34);
        @(posedge clk); #1;
        a[d] = 8'h12; b[d] = 8'h34; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        @(negedge clk);
        checks++; if (in_ready[d] !== 1'b0) $display("FAIL bp_busy_in_ready dut%0d got %b want 0", d, in_ready[d]); else passed++;
        n = 0;
        while (out_valid[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (out_valid[d] !== 1'b1) $display("FAIL bp_timeout dut%0d got out_valid %b want 1", d, out_valid[d]); else passed++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid[d] !== 1'b1 || p[d] !== e[15:0] || ovf[d] !== e[16] || in_ready[d] !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) $display("FAIL bp_hold dut%0d got %0d unstable cycles want 0 (P %h want %h)", d, bad, p[d], e[15:0]); else passed++;
        @(posedge clk); #1;
        out_ready[d] = 1'b1;
        xfers = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid[d] && out_ready[d]) xfers++;
            @(posedge clk);
        end
        checks++; if (xfers != 1) $display("FAIL bp_release dut%0d got %0d transfers want 1", d, xfers); else passed++;
    endtask

    task automatic test_back_to_back(input int d);
        logic [7:0] va[3], vb[3];
        logic [16:0] e;
        int idx, got, overlap, errs, cyc;
        bit acc_now;
        do_reset();
        va = '{8'd3, 8'd200, 8'd0};
        vb = '{8'd5, 8'd7, 8'd9};
        idx = 0; got = 0; overlap = 0; errs = 0;
        out_ready[d] = 1'b1;
        for (cyc = 0; cyc < 60 && got < 3; cyc++) begin
            @(posedge clk); #1;
            if (idx < 3) begin
                a[d] = va[idx]; b[d] = vb[idx]; in_valid[d] = 1'b1;
            end else begin
                in_valid[d] = 1'b0;
            end
            @(negedge clk);
            acc_now = in_valid[d] && in_ready[d];
            if (out_valid[d] && out_ready[d]) begin
                if (acc_now) overlap++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL b2b_extra dut%0d got unexpected result %h want none", d, p[d]);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf[d], p[d]} !== e) begin
                        errs++;
                        $display("FAIL b2b_result dut%0d got %h want %h", d, {ovf[d], p[d]}, e);
                    end
                end
                got++;
            end
            if (acc_now) begin
                exp_q.push_back(model(d, va[idx], vb[idx]));
                idx++;
            end
        end
        in_valid[d] = 1'b0;
        checks++; if (errs != 0) $display("FAIL b2b_values dut%0d got %0d errors want 0", d, errs); else passed++;
        checks++; if (got != 3 || exp_q.size() != 0) $display("FAIL b2b_count dut%0d got %0d results (%0d pending) want 3", d, got, exp_q.size()); else passed++;
        checks++; if (overlap != 2) $display("FAIL b2b_no_bubble dut%0d got %0d overlapped handoffs want 2", d, overlap); else passed++;
    endtask

    task automatic test_reset_mid(input int d);
        logic [16:0] e;
        int pulses, n;
        do_reset();
        pulses = 0;
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        a[d] = 8'hAB; b[d] = 8'hCD; in_valid[d] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            in_valid[d] = 1'b0;
            if (i == 2) rst = 1'b1;
            if (i == 4) rst = 1'b0;
            @(negedge clk);
            if (out_valid[d] === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) $display("FAIL rstmid_pulse dut%0d got %0d out_valid cycles want 0", d, pulses); else passed++;
        checks++; if (in_ready[d] !== 1'b1) $display("FAIL rstmid_in_ready dut%0d got %b want 1", d, in_ready[d]); else passed++;
        checks++; if (p[d] !== 16'h0 || ovf[d] !== 1'b0) $display("FAIL rstmid_p dut%0d got %b/%h want 0/0000", d, ovf[d], p[d]); else passed++;
        e = model(d, 8'd2, 8'd3);
        @(posedge clk); #1;
        a[d] = 8'd2; b[d] = 8'd3; in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        n = 0;
        @(negedge clk);
        while (out_valid[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (out_valid[d] !== 1'b1 || {ovf[d], p[d]} !== e) $display("FAIL rstmid_next dut%0d got valid %b val %h want 1 %h", d, out_valid[d], {ovf[d], p[d]}, e); else passed++;
    endtask

    task automatic test_random(input int d, input int n);
        logic [7:0] ra, rb;
        logic [16:0] e;
        int idx, got, errs, cyc, errbad;
        do_reset();
        idx = 0; got = 0; errs = 0; errbad = 0;
        ra = 8'($urandom); rb = 8'($urandom);
        for (cyc = 0; cyc < n * 20 && got < n; cyc++) begin
            @(posedge clk); #1;
            out_ready[d] = ($urandom_range(0, 3) != 0);
            in_valid[d] = (idx < n);
            a[d] = ra; b[d] = rb;
            @(negedge clk);
            if (out_valid[d] && out_ready[d]) begin
                if (exp_q.size() == 0) begin
                    errs++;
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf[d], p[d]} !== e) begin
                        errs++;
                        if (errs <= 5) $display("FAIL rand_result dut%0d got %h want %h", d, {ovf[d], p[d]}, e);
                    end
                end
`ifdef MULT_ERR_MON_EN
                if (err[d] !== (d == 2)) errbad++;
`endif
                got++;
            end
            if (in_valid[d] && in_ready[d]) begin
                exp_q.push_back(model(d, ra, rb));
                idx++;
                ra = 8'($urandom); rb = 8'($urandom);
            end
        end
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b0;
        checks++; if (errs != 0) $display("FAIL rand_values dut%0d got %0d errors want 0", d, errs); else passed++;
        checks++; if (got != n) $display("FAIL rand_count dut%0d got %0d results want %0d", d, got, n); else passed++;
`ifdef MULT_ERR_MON_EN
        checks++; if (errbad != 0) $display("FAIL rand_err dut%0d got %0d wrong err flags want 0", d, errbad); else passed++;
        checks++; if (err_cnt[d] !== ((d == 2) ? 16'(n) : 16'd0)) $display("FAIL rand_err_cnt dut%0d got %0d want %0d", d, err_cnt[d], (d == 2) ? n : 0); else passed++;
`else
        checks++; if (errbad != 0) $display("FAIL rand_err dut%0d got %0d want 0", d, errbad); else passed++;
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        a = '0;
        b = '0;
        for (int d = 0; d < ND; d++) begin
            test_reset(d);
            test_basic(d);
            test_backpressure(d);
            test_back_to_back(d);
            test_reset_mid(d);
        end
        test_random(0, 1000);
        test_random(1, 200);
        test_random(2, 50);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
